// File: rtl/branch_redirect_ctrl_if.sv
// Bundle between the ID/EX pipeline stages, the redirect/hazard controller and
// the fetch stage. The controller side uses the slave modport; whatever drives
// the pipeline inputs and consumes the fetch controls uses the master modport.
interface branch_redirect_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                cpu_en;
  logic                id_valid;
  logic                id_is_cond_br;
  logic                id_is_jal;
  logic [PC_WIDTH-1:0] id_pc;
  logic [PC_WIDTH-1:0] id_imm;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic                id_uses_rs1;
  logic                id_uses_rs2;
  logic                ex_mem_read;
  logic [4:0]          ex_rd;
  logic                ex_resolve_valid;
  logic                ex_taken;
  logic                is_branch;
  logic [PC_WIDTH-1:0] branch_pc;
  logic                is_restore;
  logic                is_stall;
  logic                flush_id;
  logic [1:0]          pred_ctr;

  modport master (
    output cpu_en, id_valid, id_is_cond_br, id_is_jal, id_pc, id_imm,
           id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_resolve_valid, ex_taken,
    input  is_branch, branch_pc, is_restore, is_stall, flush_id, pred_ctr
  );

  modport slave (
    input  cpu_en, id_valid, id_is_cond_br, id_is_jal, id_pc, id_imm,
           id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_resolve_valid, ex_taken,
    output is_branch, branch_pc, is_restore, is_stall, flush_id, pred_ctr
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Control-flow redirect and hazard controller for the fetch stage.
// Predicts conditional branches at ID from one global 2-bit saturating counter,
// redirects JAL unconditionally, keeps a single outstanding prediction until EX
// resolves it, corrects mispredicts (restore or redirect) and raises load-use
// stalls. All fetch controls are combinational from the current ID/EX inputs.
module branch_redirect_ctrl #(
  parameter int PC_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  branch_redirect_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RES = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          ctr;
  logic [1:0]          ctr_nxt;
  logic                pred_taken_q;
  logic                pred_taken_nxt;
  logic [PC_WIDTH-1:0] alt_target_q;
  logic [PC_WIDTH-1:0] alt_target_nxt;

  logic [PC_WIDTH-1:0] target;
  logic                load_use;
  logic                mispredict;
  logic                id_xfer;

  logic                is_branch;
  logic [PC_WIDTH-1:0] branch_pc;
  logic                is_restore;
  logic                is_stall;
  logic                flush_id;

  // Saturating update of the 2-bit direction counter toward the actual outcome.
  function automatic logic [1:0] ctr_update(input logic [1:0] cur, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cur == 2'd3) ? 2'd3 : cur + 2'd1;
    end else begin
      res = (cur == 2'd0) ? 2'd0 : cur - 2'd1;
    end
    return res;
  endfunction

  // Wrapping add: the carry out of the target is deliberately dropped.
  assign target = bus.id_pc + bus.id_imm;

  // Register x0 never creates a dependency, so it is excluded from the match.
  assign load_use = bus.id_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                    ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  assign mispredict = (state == WAIT_RES) & bus.ex_resolve_valid &
                      (bus.ex_taken != pred_taken_q);

  assign id_xfer = bus.id_valid & (bus.id_is_cond_br | bus.id_is_jal);

  // Prioritised fetch controls and next-state; a stall never coexists with a redirect.
  always_comb begin
    state_nxt      = state;
    ctr_nxt        = ctr;
    pred_taken_nxt = pred_taken_q;
    alt_target_nxt = alt_target_q;
    is_branch      = 1'b0;
    branch_pc      = '0;
    is_restore     = 1'b0;
    is_stall       = 1'b0;
    flush_id       = 1'b0;

    if (bus.cpu_en) begin
      if (mispredict) begin
        // Wrongly taken: go back to the fall-through; wrongly not-taken: jump.
        if (pred_taken_q) begin
          is_restore = 1'b1;
        end else begin
          is_branch = 1'b1;
          branch_pc = alt_target_q;
        end
        flush_id = 1'b1;
      end else if (load_use) begin
        is_stall = 1'b1;
      end else if ((state == WAIT_RES) && id_xfer) begin
        // Only one control transfer may be in flight; hold the new one in ID.
        is_stall = 1'b1;
      end else if ((state == IDLE) && bus.id_valid && bus.id_is_jal) begin
        is_branch = 1'b1;
        branch_pc = target;
        flush_id  = 1'b1;
      end else if ((state == IDLE) && bus.id_valid && bus.id_is_cond_br) begin
        if (ctr[1]) begin
          is_branch = 1'b1;
          branch_pc = target;
          flush_id  = 1'b1;
        end else begin
          is_branch = 1'b0;
        end
        state_nxt      = WAIT_RES;
        pred_taken_nxt = ctr[1];
        alt_target_nxt = target;
      end else begin
        is_stall = 1'b0;
      end

      // Resolution retires the outstanding prediction regardless of ID activity.
      case (state)
        WAIT_RES: begin
          if (bus.ex_resolve_valid) begin
            state_nxt = IDLE;
            ctr_nxt   = ctr_update(ctr, bus.ex_taken);
          end else begin
            state_nxt = state_nxt;
          end
        end
        IDLE:    state_nxt = state_nxt;
        default: state_nxt = IDLE;
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // State, counter and prediction latches; frozen while the core is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ctr          <= 2'b10;
      pred_taken_q <= 1'b0;
      alt_target_q <= '0;
    end else if (bus.cpu_en) begin
      state        <= state_nxt;
      ctr          <= ctr_nxt;
      pred_taken_q <= pred_taken_nxt;
      alt_target_q <= alt_target_nxt;
    end else begin
      state        <= state;
      ctr          <= ctr;
      pred_taken_q <= pred_taken_q;
      alt_target_q <= alt_target_q;
    end
  end

  assign bus.is_branch  = is_branch;
  assign bus.branch_pc  = branch_pc;
  assign bus.is_restore = is_restore;
  assign bus.is_stall   = is_stall;
  assign bus.flush_id   = flush_id;
  assign bus.pred_ctr   = ctr;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: a table of per-cycle vectors
// plus hand-written sequences (counter saturation, async reset mid-prediction).
// Expected records are queued when stimulus is driven and popped when the
// combinational outputs are sampled on the falling edge.
module tb_branch_redirect_ctrl;

  localparam int PW = 32;

  logic clk;
  logic rst;

  branch_redirect_ctrl_if #(.PC_WIDTH(PW)) bus_if ();

  branch_redirect_ctrl #(.PC_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en;
    logic        vld;
    logic        cond;
    logic        jal;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        mr;
    logic [4:0]  rd;
    logic        rv;
    logic        tk;
    logic        eb;
    logic [31:0] bpc;
    logic        er;
    logic        es;
    logic        ef;
    logic [1:0]  ectr;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [1:0] mctr;

  function automatic vec_t mk(string nm, logic en, logic vld, logic cond, logic jal,
                              logic [31:0] pc, logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic mr, logic [4:0] rd, logic rv, logic tk,
                              logic eb, logic [31:0] bpc, logic er, logic es, logic ef,
                              logic [1:0] ectr);
    vec_t v;
    v.name = nm; v.en = en; v.vld = vld; v.cond = cond; v.jal = jal;
    v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.mr = mr; v.rd = rd; v.rv = rv; v.tk = tk;
    v.eb = eb; v.bpc = bpc; v.er = er; v.es = es; v.ef = ef; v.ectr = ectr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus_if.cpu_en           = v.en;
    bus_if.id_valid         = v.vld;
    bus_if.id_is_cond_br    = v.cond;
    bus_if.id_is_jal        = v.jal;
    bus_if.id_pc            = v.pc;
    bus_if.id_imm           = v.imm;
    bus_if.id_rs1           = v.rs1;
    bus_if.id_rs2           = v.rs2;
    bus_if.id_uses_rs1      = v.u1;
    bus_if.id_uses_rs2      = v.u2;
    bus_if.ex_mem_read      = v.mr;
    bus_if.ex_rd            = v.rd;
    bus_if.ex_resolve_valid = v.rv;
    bus_if.ex_taken         = v.tk;
  endtask

  task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] want);
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, want);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard: got empty queue, expected a pending record");
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      chk(e.name, "is_branch",  {31'd0, bus_if.is_branch},  {31'd0, e.eb});
      chk(e.name, "branch_pc",  bus_if.branch_pc,           e.bpc);
      chk(e.name, "is_restore", {31'd0, bus_if.is_restore}, {31'd0, e.er});
      chk(e.name, "is_stall",   {31'd0, bus_if.is_stall},   {31'd0, e.es});
      chk(e.name, "flush_id",   {31'd0, bus_if.flush_id},   {31'd0, e.ef});
      chk(e.name, "pred_ctr",   {30'd0, bus_if.pred_ctr},   {30'd0, e.ectr});
    end
  endtask

  // One clock: drive just after the rising edge, compare on the falling edge.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    check_out();
  endtask

  // Conditional branch followed by its resolution, expectations from a counter model.
  task automatic br_pair(input logic tk, input logic [31:0] pc, input logic [31:0] imm);
    logic        p;
    logic [31:0] tgt;
    p   = mctr[1];
    tgt = pc + imm;
    step(mk("sat_br", 1'b1, 1'b1, 1'b1, 1'b0, pc, imm, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
            1'b0, 1'b0, p, p ? tgt : 32'd0, 1'b0, 1'b0, p, mctr));
    step(mk("sat_res", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
            1'b1, tk, (tk != p) && !p, ((tk != p) && !p) ? tgt : 32'd0, (tk != p) && p,
            1'b0, tk != p, mctr));
    if (tk) mctr = (mctr == 2'd3) ? 2'd3 : mctr + 2'd1;
    else    mctr = (mctr == 2'd0) ? 2'd0 : mctr - 2'd1;
  endtask

  initial begin
    vec_t z;
    z = mk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
           1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd2);
    rst = 1'b0;
    drive(z);
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(z);
    check_out();
    rst = 1'b1;

    //           name              en    vld   cond  jal   pc            imm            rs1   rs2   u1    u2    mr    rd    rv    tk    eb    bpc           er    es    ef    ctr
    tbl.push_back(mk("idle",        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk("jal_wrap",    1'b1, 1'b1, 1'b0, 1'b1, 32'h100,      32'hFFFFFFF0,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hF0,       1'b0, 1'b0, 1'b1, 2'd2));
    tbl.push_back(mk("idle_res_ign",1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk("br_pt",       1'b1, 1'b1, 1'b1, 1'b0, 32'h40,       32'h8,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h48,       1'b0, 1'b0, 1'b1, 2'd2));
    tbl.push_back(mk("res_nt",      1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 2'd2));
    tbl.push_back(mk("ctr1",        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk("br_pnt",      1'b1, 1'b1, 1'b1, 1'b0, 32'h100,      32'h100,       5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mk("br2_stall",   1'b1, 1'b1, 1'b1, 1'b0, 32'h104,      32'h20,        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 2'd1));
    tbl.push_back(mk("res_t_mis",   1'b1, 1'b1, 1'b1, 1'b0, 32'h104,      32'h20,        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 32'h200,      1'b0, 1'b0, 1'b1, 2'd1));
    tbl.push_back(mk("ctr2",        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk("lu_rs2",      1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 2'd2));
    tbl.push_back(mk("lu_rd0",      1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk("lu_rs1_off",  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk("lu_over_jal", 1'b1, 1'b1, 1'b0, 1'b1, 32'h300,      32'h4,         5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 2'd2));
    tbl.push_back(mk("br_pt2",      1'b1, 1'b1, 1'b1, 1'b0, 32'h500,      32'h10,        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h510,      1'b0, 1'b0, 1'b1, 2'd2));
    tbl.push_back(mk("res_ok_stall",1'b1, 1'b1, 1'b1, 1'b0, 32'h600,      32'h10,        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 2'd2));
    tbl.push_back(mk("ctr3",        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd3));
    tbl.push_back(mk("br_pt3",      1'b1, 1'b1, 1'b1, 1'b0, 32'h700,      32'hFFFFFFFC,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h6FC,      1'b0, 1'b0, 1'b1, 2'd3));
    tbl.push_back(mk("mis_over_lu", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 2'd3));
    tbl.push_back(mk("ctr2b",       1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk("br_pt4",      1'b1, 1'b1, 1'b1, 1'b0, 32'h800,      32'h80,        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h880,      1'b0, 1'b0, 1'b1, 2'd2));
    tbl.push_back(mk("en0_res",     1'b0, 1'b1, 1'b1, 1'b0, 32'h900,      32'h4,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk("en0_lu",      1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2));
    tbl.push_back(mk("still_wait",  1'b1, 1'b1, 1'b1, 1'b0, 32'h900,      32'h4,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 2'd2));
    tbl.push_back(mk("res_nt2",     1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 2'd2));
    tbl.push_back(mk("ctr1b",       1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // Saturation: counter starts at 1, four taken then five not-taken outcomes.
    mctr = 2'd1;
    for (int i = 0; i < 4; i++) br_pair(1'b1, 32'h1000 + 32'(i * 64), 32'h20);
    for (int i = 0; i < 5; i++) br_pair(1'b0, 32'h2000 + 32'(i * 64), 32'h40);
    step(mk("sat_floor", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mctr));

    // Async reset while a not-taken prediction is outstanding.
    step(mk("rw_br", 1'b1, 1'b1, 1'b1, 1'b0, 32'hA00, 32'h40, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0));
    @(posedge clk);
    #1;
    z = mk("rw_pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
           1'b1, 1'b1, 1'b1, 32'hA40, 1'b0, 1'b0, 1'b1, 2'd0);
    drive(z);
    exp_q.push_back(z);
    #1;
    check_out();
    rst = 1'b0;
    #1;
    z.name = "rw_in_rst"; z.eb = 1'b0; z.bpc = 32'h0; z.ef = 1'b0; z.ectr = 2'd2;
    exp_q.push_back(z);
    check_out();
    @(negedge clk);
    rst = 1'b1;
    step(mk("rw_after", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
            1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2));
    step(mk("rw_br_pt", 1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 2'd2));
    step(mk("rw_res_ok", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
            1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd2));
    step(mk("rw_ctr3", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
            1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd3));

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog so the run always ends even if the stimulus thread stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Control-flow redirect and hazard controller that drives the fetch stage's `is_branch`, `branch_pc`, `is_restore` and `is_stall` inputs. It sits beside decode/execute:
- predicts conditional branches at ID with a global 2-bit saturating counter;
- redirects unconditionally for JAL;
- tracks one outstanding prediction until EX resolves it;
- raises load-use stalls.

On a mispredict it issues the correction to fetch (restore for wrongly-taken, redirect for wrongly-not-taken) and flushes ID.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of PCs and immediates.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_en` in 1: global enable; 0 freezes all state and forces redirect/stall outputs to 0.
- `id_valid` in 1: ID holds a valid instruction.
- `id_is_cond_br` in 1: ID instruction is a conditional branch.
- `id_is_jal` in 1: ID instruction is JAL.
- `id_pc` in PC_WIDTH: PC of the ID instruction.
- `id_imm` in PC_WIDTH: sign-extended byte offset.
- `id_rs1`, `id_rs2` in 5 each: ID source registers.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: source-register read enables.
- `ex_mem_read` in 1: EX instruction is a load.
- `ex_rd` in 5: EX destination register.
- `ex_resolve_valid` in 1: EX is resolving the outstanding conditional branch this cycle.
- `ex_taken` in 1: actual outcome of that branch.
- `is_branch` out 1: fetch loads `branch_pc` (and saves its pc+4 as restore address).
- `branch_pc` out PC_WIDTH: redirect target.
- `is_restore` out 1: fetch returns to its saved restore address.
- `is_stall` out 1: fetch holds PC.
- `flush_id` out 1: ID/EX register must capture a bubble next edge.
- `pred_ctr` out 2: current counter value (debug).

## Operation
- State: FSM {IDLE, WAIT_RES}, 2-bit counter `ctr`, 1-bit `pred_taken_q`, PC_WIDTH `alt_target_q`.
- Reset: IDLE, `ctr` = 2'b10, `pred_taken_q` = 0, `alt_target_q` = 0. All outputs are combinational; with inputs at 0 every output is 0 except `pred_ctr` = 2'b10.
- `target = id_pc + id_imm`, modulo 2^PC_WIDTH (wrap-around, no carry out). Predict taken iff `ctr[1]`.
- `load_use = id_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`.
- `mispredict = (state == WAIT_RES) & ex_resolve_valid & (ex_taken != pred_taken_q)`.
- Output priority per cycle, cpu_en = 1:
  1. `mispredict`:
     - if `pred_taken_q` = 1: `is_restore` = 1.
     - else: `is_branch` = 1 with `branch_pc` = `alt_target_q`.
     - in both cases: `flush_id` = 1 and `is_stall` = 0.
  2. `load_use`: `is_stall` = 1. No redirect.
  3. WAIT_RES with `id_valid & (id_is_cond_br | id_is_jal)` (one outstanding transfer only, including the resolution cycle): `is_stall` = 1.
  4. IDLE, `id_valid & id_is_jal`: `is_branch` = 1, `branch_pc` = `target`, `flush_id` = 1. State unchanged.
  5. IDLE, `id_valid & id_is_cond_br`:
     - predicted taken: `is_branch` = 1, `branch_pc` = `target`, `flush_id` = 1.
     - predicted not-taken: no redirect.
     - in both cases: go to WAIT_RES, latch `pred_taken_q` = `ctr[1]` and `alt_target_q` = `target`.
- `is_stall` is never 1 in the same cycle as `is_branch` or `is_restore`; fetch ignores redirects while stalled.
- WAIT_RES → IDLE on any `ex_resolve_valid`. At the same edge `ctr` saturates: +1 if `ex_taken` (max 3), −1 otherwise (min 0). `ex_resolve_valid` in IDLE is ignored; no counter update.
- JAL never updates `ctr`. `branch_pc` = 0 whenever `is_branch` = 0.
- `cpu_en` = 0: no state, counter or latch update; `is_branch`, `is_restore`, `is_stall` and `flush_id` all 0.
- Asynchronous reset mid-WAIT_RES discards the outstanding prediction immediately.

## Timing
- Redirect latency: zero cycles combinational from ID/EX inputs. Fetch PC changes at the next rising edge.
- Taken-predicted branch or JAL costs one bubble (`flush_id`). A mispredict costs the EX-resolution distance plus one flushed ID slot.
- All state updates on the rising edge of `clk`, gated by `cpu_en`. Reset acts asynchronously on the falling edge of `rst`; release is synchronous to `clk`.

## Test plan
- Reset then one idle clock: all control outputs 0, `pred_ctr` = 2'b10.
- IDLE, JAL with `id_pc` = 0x100, `id_imm` = 0xFFFFFFF0 → `is_branch` = 1, `branch_pc` = 0xF0, `flush_id` = 1; state stays IDLE; `ctr` unchanged.
- Branch predicted taken (`ctr` = 2), `id_pc` = 0x40, `id_imm` = 8 → `is_branch` = 1, `branch_pc` = 0x48. Next cycle resolve with `ex_taken` = 0 → `is_restore` = 1, `flush_id` = 1, `is_stall` = 0, `ctr` → 1, state → IDLE.
- With `ctr` = 1, branch predicted not-taken, target 0x200, resolved taken → `is_branch` = 1, `branch_pc` = 0x200, `ctr` → 2. Drive a second branch in ID during WAIT_RES → `is_stall` = 1 until resolution completes.
- Load-use: `ex_mem_read` = 1, `ex_rd` = 5, `id_rs2` = 5, `id_uses_rs2` = 1 → `is_stall` = 1. With `ex_rd` = 0 → `is_stall` = 0. Mispredict in the same cycle → `is_stall` = 0 and the correction wins.
- Counter saturation: four taken resolutions hold `ctr` at 3; four not-taken resolutions hold it at 0. With `cpu_en` = 0 during a resolve, `ctr` and state are unchanged; assert `rst` low in WAIT_RES → IDLE and `ctr` = 2 immediately.
